vp_key_event_queue: RTL and testbench

// - Merges PS/2 key events and gamepad numpad buttons into one ordered event queue feeding vp_keymap (rx_* handshake).
// - Replaces the single-register PS/2/joystick mux; joystick releases are never lost, so keys no longer stick.
// - Sits in the clk_sys domain between data_io/joystick inputs and vp_keymap.

---
 rtl/vp_input_pkg.sv | 43 ++++
 rtl/vp_event_fifo.sv | 56 +++++
 rtl/vp_key_event_queue.sv | 146 ++++++++++++++
 tb/tb_vp_key_event_queue.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vp_input_pkg.sv
// Shared types and lookup helpers for the keyboard/gamepad event path.
// key_evt_t is the queued entry: release flag plus the ASCII code handed to vp_keymap.
package vp_input_pkg;

  localparam logic [7:0] KEY_NONE = 8'h00;

  typedef struct packed {
    logic       released;
    logic [7:0] ascii;
  } key_evt_t;

  // PS/2 set-2 make codes; anything not listed returns KEY_NONE and is never queued
  function automatic logic [7:0] scancode_to_ascii(input logic [7:0] code);
    logic [7:0] a;
    a = KEY_NONE;
    case (code)
      8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;  8'h25: a = 8'h34;
      8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;  8'h3E: a = 8'h38;
      8'h46: a = 8'h39;  8'h45: a = 8'h30;
      8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
      8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
      8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
      8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
      8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
      8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
      8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
      8'h29: a = 8'h20;  8'h4E: a = 8'h2D;  8'h55: a = 8'h3D;  8'h4A: a = 8'h2F;
      8'h49: a = 8'h2E;  8'h41: a = 8'h2C;
      // console yes/no keys
      8'h11: a = 8'h79;  8'h12: a = 8'h6E;
      8'h5A: a = 8'd10;  8'h66: a = 8'd8;
      default: a = KEY_NONE;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] joy_index_to_ascii(input int k);
    if (k >= 0 && k < 9) return 8'h31 + 8'(k);
    else if (k == 9)     return 8'h30;
    else                 return KEY_NONE;
  endfunction

endpackage

// File: rtl/vp_event_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module vp_event_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     res_n_i,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign empty_o = (r_count == '0);
  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign level_o = r_count;
  assign rdata_o = r_mem[r_rd_ptr];
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // storage needs no reset: the count decides what is valid
  always_ff @(posedge clk_i) begin
    if (w_push && !clr_i) r_mem[r_wr_ptr] <= wdata_i;
  end

endmodule

// File: rtl/vp_key_event_queue.sv
// Merges PS/2 key events and gamepad numpad buttons into one ordered queue for vp_keymap.
// Handshake: rx_data_ready_o presents the head; rx_read_i & rx_data_ready_o pops it, then ready idles one cycle.
module vp_key_event_queue
  import vp_input_pkg::*;
#(
  parameter int NUM_JOY_KEYS = 10,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk_i,
  input  logic                          res_n_i,
  input  logic [10:0]                   ps2_key_i,
  input  logic [NUM_JOY_KEYS-1:0]       joy_keys_i,
  input  logic                          flush_i,
  output logic                          rx_data_ready_o,
  output logic [7:0]                    rx_ascii_o,
  output logic                          rx_released_o,
  input  logic                          rx_read_i,
  output logic                          overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  function automatic logic [NUM_JOY_KEYS-1:0] valid_joy_mask();
    logic [NUM_JOY_KEYS-1:0] m;
    for (int k = 0; k < NUM_JOY_KEYS; k++) m[k] = (joy_index_to_ascii(k) != KEY_NONE);
    return m;
  endfunction

  localparam logic [NUM_JOY_KEYS-1:0] JOY_MASK = valid_joy_mask();

  logic                    r_primed;
  logic                    r_ps2_tog;
  logic                    r_ps2_vld;
  key_evt_t                r_ps2_evt;
  logic [NUM_JOY_KEYS-1:0] r_joy_hist;
  logic [NUM_JOY_KEYS-1:0] r_joy_pend;
  logic                    r_rx_ready;
  key_evt_t                r_rx_evt;
  logic                    r_overflow;

  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  key_evt_t                w_fifo_head;
  logic [$clog2(FIFO_DEPTH):0] w_level;
  logic [7:0]              w_ps2_ascii;
  logic                    w_unused_ext;
  logic                    w_pop;
  logic                    w_space;
  logic                    w_joy_hit;
  logic                    w_joy_take;
  key_evt_t                w_joy_evt;
  logic [NUM_JOY_KEYS-1:0] w_joy_sel;
  logic [NUM_JOY_KEYS-1:0] w_edges;
  key_evt_t                w_push_evt;
  logic                    w_push;
  key_evt_t                w_next;

  assign w_ps2_ascii  = scancode_to_ascii(ps2_key_i[7:0]);
  assign w_unused_ext = ps2_key_i[8];
  assign w_pop        = rx_read_i && r_rx_ready;
  assign w_space      = !w_fifo_full || w_pop;
  assign w_edges      = (joy_keys_i ^ r_joy_hist) & JOY_MASK;

  // lowest-index pending button wins; the descending loop lets index 0 overwrite last
  always_comb begin
    w_joy_hit = 1'b0;
    w_joy_evt = '0;
    w_joy_sel = '0;
    for (int k = NUM_JOY_KEYS - 1; k >= 0; k--) begin
      if (r_joy_pend[k]) begin
        w_joy_hit          = 1'b1;
        w_joy_evt.released = ~r_joy_hist[k];
        w_joy_evt.ascii    = joy_index_to_ascii(k);
        w_joy_sel          = '0;
        w_joy_sel[k]       = 1'b1;
      end
    end
  end

  assign w_joy_take = !r_ps2_vld && w_joy_hit && w_space;
  assign w_push_evt = r_ps2_vld ? r_ps2_evt : w_joy_evt;
  assign w_push     = (r_ps2_vld || w_joy_hit) && w_space && !flush_i;
  // an entry written into an empty FIFO is presented in the same edge to keep latency at two cycles
  assign w_next     = w_fifo_empty ? w_push_evt : w_fifo_head;

  vp_event_fifo #(.WIDTH($bits(key_evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .res_n_i (res_n_i),
    .clr_i   (flush_i),
    .push_i  (w_push),
    .wdata_i (w_push_evt),
    .pop_i   (w_pop),
    .rdata_o (w_fifo_head),
    .full_o  (w_fifo_full),
    .empty_o (w_fifo_empty),
    .level_o (w_level)
  );

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      r_primed   <= 1'b0;
      r_ps2_tog  <= 1'b0;
      r_ps2_vld  <= 1'b0;
      r_ps2_evt  <= '0;
      r_joy_hist <= '0;
      r_joy_pend <= '0;
      r_rx_ready <= 1'b0;
      r_rx_evt   <= '0;
      r_overflow <= 1'b0;
    end else if (flush_i) begin
      r_primed   <= 1'b0;
      r_ps2_vld  <= 1'b0;
      r_joy_hist <= joy_keys_i;
      r_joy_pend <= '0;
      r_rx_ready <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_ps2_vld <= 1'b0;
      if (!r_primed) begin
        r_primed  <= 1'b1;
        r_ps2_tog <= ps2_key_i[10];
      end else if (ps2_key_i[10] != r_ps2_tog) begin
        r_ps2_tog          <= ps2_key_i[10];
        r_ps2_vld          <= (w_ps2_ascii != KEY_NONE);
        r_ps2_evt.released <= ~ps2_key_i[9];
        r_ps2_evt.ascii    <= w_ps2_ascii;
      end
      if (r_ps2_vld && !w_space) r_overflow <= 1'b1;
      // a fresh edge on the serviced bit keeps it pending so the final level is still reported
      r_joy_pend <= (r_joy_pend & ~(w_joy_take ? w_joy_sel : '0)) | w_edges;
      r_joy_hist <= joy_keys_i;
      if (w_pop) begin
        r_rx_ready <= 1'b0;
      end else if (!r_rx_ready && (!w_fifo_empty || w_push)) begin
        r_rx_ready <= 1'b1;
        r_rx_evt   <= w_next;
      end
    end
  end

  assign rx_data_ready_o = r_rx_ready;
  assign rx_ascii_o      = r_rx_evt.ascii;
  assign rx_released_o   = r_rx_evt.released;
  assign overflow_o      = r_overflow;
  assign level_o         = w_level;

endmodule

// File: tb/tb_vp_key_event_queue.sv
// Bench for vp_key_event_queue: queue-level reference model checked every cycle, plus directed literal checks.
module tb_vp_key_event_queue;

  localparam int NJ    = 10;
  localparam int DEPTH = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  // clock / reset
  logic clk = 1'b0;
  logic res_n = 1'b0;
  always #5 clk = ~clk;

  logic [10:0]   ps2 = '0;
  logic [NJ-1:0] joy = '0;
  logic          flush = 1'b0;
  logic          rd = 1'b0;
  logic          rx_ready;
  logic [7:0]    rx_ascii;
  logic          rx_rel;
  logic          ovf;
  logic [LW-1:0] level;

  vp_key_event_queue #(.NUM_JOY_KEYS(NJ), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .res_n_i         (res_n),
    .ps2_key_i       (ps2),
    .joy_keys_i      (joy),
    .flush_i         (flush),
    .rx_data_ready_o (rx_ready),
    .rx_ascii_o      (rx_ascii),
    .rx_released_o   (rx_rel),
    .rx_read_i       (rd),
    .overflow_o      (ovf),
    .level_o         (level)
  );

  int  n_vec = 0;
  int  n_err = 0;
  bit  cmp_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // reference tables
  function automatic logic [7:0] tb_ascii(input logic [7:0] code);
    case (code)
      8'h16: return "1";  8'h1E: return "2";  8'h26: return "3";  8'h25: return "4";
      8'h2E: return "5";  8'h36: return "6";  8'h3D: return "7";  8'h3E: return "8";
      8'h46: return "9";  8'h45: return "0";  8'h1C: return "A";  8'h1A: return "Z";
      8'h29: return " ";  8'h5A: return 8'd10; 8'h66: return 8'd8;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] joy_ascii(input int k);
    return (k < 9) ? 8'(48 + 1 + k) : "0";
  endfunction

  logic [7:0] dcode [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45};
  logic [7:0] rcode [18] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46, 8'h45,
                             8'h1C, 8'h1A, 8'h29, 8'h5A, 8'h66, 8'h05, 8'h76, 8'h00};

  // behavioural model: the queue contents in order, plus what the consumer currently sees
  logic [8:0]    exp_q[$];
  bit            m_ready, m_ovf, m_primed, m_tog, m_st_v;
  logic [8:0]    m_out, m_st;
  logic [NJ-1:0] m_hist, m_pend;

  task automatic model_reset();
    exp_q.delete();
    m_ready = 0; m_ovf = 0; m_primed = 0; m_tog = 0; m_st_v = 0;
    m_out = '0; m_st = '0; m_hist = '0; m_pend = '0;
  endtask

  task automatic model_step();
    bit pop, space, push;
    logic [8:0] e;
    logic [7:0] a;
    int k;
    if (flush) begin
      exp_q.delete();
      m_ready = 0; m_ovf = 0; m_primed = 0; m_pend = '0; m_hist = joy; m_st_v = 0;
      return;
    end
    pop   = rd && m_ready;
    space = (exp_q.size() < DEPTH) || pop;
    push  = 0;
    e     = '0;
    if (m_st_v) begin
      if (space) begin push = 1; e = m_st; end
      else m_ovf = 1;
    end else if (m_pend != '0 && space) begin
      k = 0;
      while (!m_pend[k]) k++;
      push = 1;
      e = {~m_hist[k], joy_ascii(k)};
      m_pend[k] = 1'b0;
    end
    m_st_v = 0;
    if (!m_primed) begin
      m_primed = 1;
      m_tog = ps2[10];
    end else if (ps2[10] != m_tog) begin
      m_tog = ps2[10];
      a = tb_ascii(ps2[7:0]);
      if (a != 8'h00) begin m_st_v = 1; m_st = {~ps2[9], a}; end
    end
    m_pend = m_pend | (joy ^ m_hist);
    m_hist = joy;
    if (pop) void'(exp_q.pop_front());
    if (push) exp_q.push_back(e);
    if (pop) m_ready = 0;
    else if (!m_ready && exp_q.size() > 0) begin m_ready = 1; m_out = exp_q[0]; end
  endtask

  always @(posedge clk or negedge res_n) begin
    if (!res_n) model_reset();
    else model_step();
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (cmp_en && res_n) begin
      check("ready", 32'(rx_ready), 32'(m_ready));
      check("ascii", 32'(rx_ascii), 32'(m_out[7:0]));
      check("released", 32'(rx_rel), 32'(m_out[8]));
      check("level", 32'(level), 32'(exp_q.size()));
      check("overflow", 32'(ovf), 32'(m_ovf));
    end
  end

  // driver tasks
  task automatic take(input logic [7:0] a, input logic r, input string nm);
    int n = 0;
    while (!rx_ready && n < 40) begin @(negedge clk); n++; end
    check({nm, "_ready"}, 32'(rx_ready), 32'd1);
    check({nm, "_ascii"}, 32'(rx_ascii), 32'(a));
    check({nm, "_rel"}, 32'(rx_rel), 32'(r));
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic send_digits(input int n);
    for (int i = 0; i < n; i++) begin
      ps2 = {~ps2[10], 1'b1, 1'b0, dcode[i]};
      @(negedge clk);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(rx_ready), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ascii", 32'(rx_ascii), 32'd0);
    res_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    // PS/2 latency and handshake gap
    ps2 = {~ps2[10], 1'b1, 9'h016};
    @(negedge clk);
    check("lat1_ready", 32'(rx_ready), 32'd0);
    @(negedge clk);
    check("lat2_ready", 32'(rx_ready), 32'd1);
    check("lat2_ascii", 32'(rx_ascii), 32'h31);
    check("lat2_rel", 32'(rx_rel), 32'd0);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("ack_gap_ready", 32'(rx_ready), 32'd0);
    check("ack_level", 32'(level), 32'd0);

    // two buttons rising and falling together
    joy = 10'b00_0000_1001;
    take("1", 1'b0, "joy_p1");
    take("4", 1'b0, "joy_p4");
    joy = '0;
    take("1", 1'b1, "joy_r1");
    take("4", 1'b1, "joy_r4");

    // overflow, then a one-cycle button pulse while full
    send_digits(DEPTH + 1);
    repeat (3) @(negedge clk);
    check("full_level", 32'(level), 32'(DEPTH));
    check("full_ovf", 32'(ovf), 32'd1);
    joy[2] = 1'b1;
    @(negedge clk);
    joy[2] = 1'b0;
    repeat (3) @(negedge clk);
    check("full_level_held", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) take(8'(8'h31 + i), 1'b0, "drain");
    take("3", 1'b1, "pulse_rel");
    repeat (3) @(negedge clk);
    check("drained_level", 32'(level), 32'd0);
    check("drained_ready", 32'(rx_ready), 32'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ovf", 32'(ovf), 32'd0);

    // unmapped code, flush with a held button
    ps2 = {~ps2[10], 1'b1, 9'h005};
    repeat (4) @(negedge clk);
    check("unmapped_level", 32'(level), 32'd0);
    joy[5] = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (4) @(negedge clk);
    check("flush_held_level", 32'(level), 32'd0);
    check("flush_held_ready", 32'(rx_ready), 32'd0);
    joy[5] = 1'b0;
    take("6", 1'b1, "after_flush_rel");

    // async reset mid-handshake
    send_digits(DEPTH + 1);
    repeat (3) @(negedge clk);
    check("pre_rst_ready", 32'(rx_ready), 32'd1);
    check("pre_rst_ovf", 32'(ovf), 32'd1);
    joy[9] = 1'b1;
    #2 res_n = 1'b0;
    #1;
    check("arst_ready", 32'(rx_ready), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_ovf", 32'(ovf), 32'd0);
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    take("0", 1'b0, "held_after_rst");
    joy = '0;
    take("0", 1'b1, "held_release");

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0)
        ps2 = {~ps2[10], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rcode[$urandom_range(0, 17)]};
      if ($urandom_range(0, 6) == 0) begin
        int j;
        j = $urandom_range(0, NJ - 1);
        joy[j] = ~joy[j];
      end
      rd    = (c < 1000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
      flush = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    flush = 1'b0;
    rd = 1'b1;
    repeat (40) @(negedge clk);
    rd = 1'b0;
    check("final_level", 32'(level), 32'd0);
    @(negedge clk);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
